// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store unit.
//   lsu_state_e  - FSM state encoding
//   F3_*         - RV32I load/store funct3 codes
//   lsu_legal()  - access legality (alignment and funct3/direction check)
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only exist for loads; halves need even addresses,
  // words need word-aligned addresses.
  function automatic logic lsu_legal(input logic       wr,
                                     input logic [2:0] f3,
                                     input logic [1:0] a);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~a[0];
      F3_W:    ok = (a == 2'b00);
      F3_BU:   ok = ~wr;
      F3_HU:   ok = ~wr & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational sub-word lane handling.
//   iWord    - word read from RAM
//   iNew     - store data (only low byte/half used for sb/sh)
//   iOff     - byte offset addr[1:0]
//   iFunct3  - access type
//   oLoad    - selected byte/half, sign- or zero-extended (full word for lw)
//   oMerged  - iWord with the store lane replaced by iNew (iNew for sw)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] iWord,
  input  logic [31:0] iNew,
  input  logic [1:0]  iOff,
  input  logic [2:0]  iFunct3,
  output logic [31:0] oLoad,
  output logic [31:0] oMerged
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  always_comb begin
    case (iOff)
      2'd0:    byte_w = iWord[7:0];
      2'd1:    byte_w = iWord[15:8];
      2'd2:    byte_w = iWord[23:16];
      default: byte_w = iWord[31:24];
    endcase
    half_w = iOff[1] ? iWord[31:16] : iWord[15:0];
  end

  always_comb begin
    case (iFunct3)
      F3_B:    oLoad = {{24{byte_w[7]}}, byte_w};
      F3_H:    oLoad = {{16{half_w[15]}}, half_w};
      F3_W:    oLoad = iWord;
      F3_BU:   oLoad = {24'b0, byte_w};
      F3_HU:   oLoad = {16'b0, half_w};
      default: oLoad = '0;
    endcase
  end

  always_comb begin
    oMerged = iWord;
    case (iFunct3[1:0])
      2'b00: begin
        case (iOff)
          2'd0:    oMerged[7:0]   = iNew[7:0];
          2'd1:    oMerged[15:8]  = iNew[7:0];
          2'd2:    oMerged[23:16] = iNew[7:0];
          default: oMerged[31:24] = iNew[7:0];
        endcase
      end
      2'b01: begin
        if (iOff[1]) oMerged[31:16] = iNew[15:0];
        else         oMerged[15:0]  = iNew[15:0];
      end
      default: oMerged = iNew;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RV32I data-memory access unit for a word-wide
// RAM without byte enables (sub-word stores are read-modify-write).
//   iCLK, iRST            - clock, synchronous active-high reset
//   iReq/iWrite/iFunct3/iAddr/iWData - request, held stable until oDone
//   oBusy/oDone/oErr/oRData          - status and extended load result
//   oMemAddr/oMemWData/oMemWren/oMemRden/iMemQ - RAM port (MEM_LAT read latency)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_LAT    = 1
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iReq,
  input  logic                  iWrite,
  input  logic [2:0]            iFunct3,
  input  logic [31:0]           iAddr,
  input  logic [31:0]           iWData,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oErr,
  output logic [31:0]           oRData,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic [31:0]           oMemWData,
  output logic                  oMemWren,
  output logic                  oMemRden,
  input  logic [31:0]           iMemQ
);

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  lsu_state_e              state_q, state_d;
  logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [2:0]              f3_q, f3_d;
  logic                    write_q, write_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    err_arm_q, err_arm_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [31:0]             memw_q, memw_d;
  logic [31:0]             ld_val, merged;

  // Address bits above the RAM range are dropped, so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^iAddr[31:ADDR_WIDTH+2];

  lsu_align u_align (
    .iWord   (iMemQ),
    .iNew    (wdata_q),
    .iOff    (addr_q[1:0]),
    .iFunct3 (f3_q),
    .oLoad   (ld_val),
    .oMerged (merged)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    write_d   = write_q;
    cnt_d     = cnt_q;
    err_arm_d = err_arm_q;
    rdata_d   = rdata_q;
    memw_d    = memw_q;
    case (state_q)
      S_IDLE: begin
        if (iReq) begin
          addr_d    = iAddr[ADDR_WIDTH+1:0];
          wdata_d   = iWData;
          f3_d      = iFunct3;
          write_d   = iWrite;
          err_arm_d = 1'b0;
          if (!lsu_legal(iWrite, iFunct3, iAddr[1:0])) begin
            state_d = S_ERR;
            rdata_d = '0;
          end else if (!iWrite) begin
            state_d = S_RD;
          end else if (iFunct3 == F3_W) begin
            state_d = S_WR;
            memw_d  = iWData;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        cnt_d   = LAT_M1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          if (write_q) begin
            memw_d  = merged;
            state_d = S_WR;
          end else begin
            rdata_d = ld_val;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_WR:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      // Rejections spend one quiet cycle before reporting, so the core sees
      // the same turnaround as the fastest legal access (sw).
      S_ERR: begin
        if (err_arm_q) state_d = S_IDLE;
        else           err_arm_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      err_arm_q <= 1'b0;
      rdata_q   <= '0;
      memw_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      write_q   <= write_d;
      cnt_q     <= cnt_d;
      err_arm_q <= err_arm_d;
      rdata_q   <= rdata_d;
      memw_q    <= memw_d;
    end
  end

  assign oBusy     = (state_q != S_IDLE);
  assign oDone     = (state_q == S_DONE) | ((state_q == S_ERR) & err_arm_q);
  assign oErr      = (state_q == S_ERR) & err_arm_q;
  assign oRData    = rdata_q;
  assign oMemAddr  = addr_q[ADDR_WIDTH+1:2];
  assign oMemWData = memw_q;
  assign oMemRden  = (state_q == S_RD);
  // Gating the write with reset keeps an interrupted RMW from reaching RAM.
  assign oMemWren  = (state_q == S_WR) & ~iRST;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: two units (MEM_LAT=1 and MEM_LAT=2) share the request bus,
// each with its own behavioural RAM, and are checked side by side.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req1, req2, wr;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;

  logic        busy1, done1, err1, wren1, rden1;
  logic [31:0] rdat1, mwd1, q1;
  logic [9:0]  ma1;
  logic        busy2, done2, err2, wren2, rden2;
  logic [31:0] rdat2, mwd2, q2a, q2b;
  logic [9:0]  ma2;

  load_store_unit #(.ADDR_WIDTH(10), .MEM_LAT(1)) u1 (
    .iCLK(clk), .iRST(rst), .iReq(req1), .iWrite(wr), .iFunct3(f3),
    .iAddr(addr), .iWData(wdata), .oBusy(busy1), .oDone(done1), .oErr(err1),
    .oRData(rdat1), .oMemAddr(ma1), .oMemWData(mwd1), .oMemWren(wren1),
    .oMemRden(rden1), .iMemQ(q1));

  load_store_unit #(.ADDR_WIDTH(10), .MEM_LAT(2)) u2 (
    .iCLK(clk), .iRST(rst), .iReq(req2), .iWrite(wr), .iFunct3(f3),
    .iAddr(addr), .iWData(wdata), .oBusy(busy2), .oDone(done2), .oErr(err2),
    .oRData(rdat2), .oMemAddr(ma2), .oMemWData(mwd2), .oMemWren(wren2),
    .oMemRden(rden2), .iMemQ(q2b));

  logic [31:0] mem1 [1024];
  logic [31:0] mem2 [1024];
  logic        pre_we;
  logic [9:0]  pre_a;
  logic [31:0] pre_d;

  always @(posedge clk) begin
    if (pre_we)     mem1[pre_a] <= pre_d;
    else if (wren1) mem1[ma1]   <= mwd1;
    if (rden1)      q1          <= mem1[ma1];
  end

  always @(posedge clk) begin
    if (pre_we)     mem2[pre_a] <= pre_d;
    else if (wren2) mem2[ma2]   <= mwd2;
    if (rden2)      q2a         <= mem2[ma2];
    q2b <= q2a;
  end

  int errs = 0, checks = 0;

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk); pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk); pre_we = 1'b0;
  endtask

  // Results of the last access, per unit.
  int          lat1, lat2, nr1, nw1, nr2, nw2, clash;
  logic [31:0] res1, res2;
  logic        er1, er2;
  logic [9:0]  wa1;
  bit          d1, d2;

  task acc(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = w; f3 = f; addr = a; wdata = d; req1 = 1'b1; req2 = 1'b1;
    lat1 = -1; lat2 = -1; nr1 = 0; nw1 = 0; nr2 = 0; nw2 = 0; clash = 0;
    res1 = '0; res2 = '0; er1 = 1'b0; er2 = 1'b0; wa1 = '0; d1 = 1'b0; d2 = 1'b0;
    @(posedge clk);  // accept edge k
    for (int n = 1; n <= 20 && !(d1 && d2); n++) begin
      @(negedge clk);
      if (rden1 && wren1) clash++;
      if (rden2 && wren2) clash++;
      if (!d1) begin
        nr1 += int'(rden1); nw1 += int'(wren1);
        if (wren1) wa1 = ma1;
        if (done1) begin d1 = 1'b1; lat1 = n; res1 = rdat1; er1 = err1; req1 = 1'b0; end
      end
      if (!d2) begin
        nr2 += int'(rden2); nw2 += int'(wren2);
        if (done2) begin d2 = 1'b1; lat2 = n; res2 = rdat2; er2 = err2; req2 = 1'b0; end
      end
    end
    req1 = 1'b0; req2 = 1'b0;
  endtask

  task exp_acc(input string t, input int el1, input int el2, input int enr, input int enw,
               input logic ee, input bit cres, input logic [31:0] eres);
    chk({t, ":lat1"}, lat1, el1);
    chk({t, ":lat2"}, lat2, el2);
    chk({t, ":err1"}, {31'b0, er1}, {31'b0, ee});
    chk({t, ":err2"}, {31'b0, er2}, {31'b0, ee});
    chk({t, ":rdwr1"}, {nr1[15:0], nw1[15:0]}, {enr[15:0], enw[15:0]});
    chk({t, ":rdwr2"}, {nr2[15:0], nw2[15:0]}, {enr[15:0], enw[15:0]});
    chk({t, ":clash"}, clash, 0);
    if (cres) begin
      chk({t, ":res1"}, res1, eres);
      chk({t, ":res2"}, res2, eres);
    end
  endtask

  task chk_reset_outs(input string t);
    chk({t, ":ctl1"}, {27'b0, busy1, done1, err1, wren1, rden1}, 32'd0);
    chk({t, ":ctl2"}, {27'b0, busy2, done2, err2, wren2, rden2}, 32'd0);
    chk({t, ":rdat1"}, rdat1, 32'd0);
    chk({t, ":rdat2"}, rdat2, 32'd0);
    chk({t, ":maddr1"}, {22'b0, ma1}, 32'd0);
    chk({t, ":mwd1"}, mwd1, 32'd0);
    chk({t, ":mwd2"}, mwd2, 32'd0);
  endtask

  int wseen;

  initial begin
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0; wr = 1'b0; f3 = '0; addr = '0; wdata = '0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;

    preload(10'h1, 32'h80FF7F01);
    preload(10'h4, 32'h11223344);

    // Loads from word 0x4: load oDone at k+2+MEM_LAT.
    acc(1'b0, F3_B,  32'h7, '0); exp_acc("lb7",  3, 4, 1, 0, 1'b0, 1'b1, 32'hFFFFFF80);
    acc(1'b0, F3_BU, 32'h7, '0); exp_acc("lbu7", 3, 4, 1, 0, 1'b0, 1'b1, 32'h00000080);
    acc(1'b0, F3_H,  32'h6, '0); exp_acc("lh6",  3, 4, 1, 0, 1'b0, 1'b1, 32'hFFFF80FF);
    acc(1'b0, F3_W,  32'h4, '0); exp_acc("lw4",  3, 4, 1, 0, 1'b0, 1'b1, 32'h80FF7F01);
    acc(1'b0, F3_HU, 32'h4, '0); exp_acc("lhu4", 3, 4, 1, 0, 1'b0, 1'b1, 32'h00007F01);
    acc(1'b0, F3_B,  32'h5, '0); exp_acc("lb5",  3, 4, 1, 0, 1'b0, 1'b1, 32'h0000007F);

    // Sub-word stores into word 0x10: oDone at k+3+MEM_LAT, upper data bits ignored.
    acc(1'b1, F3_B, 32'h12, 32'hFFFFFFAB); exp_acc("sb12", 4, 5, 1, 1, 1'b0, 1'b0, '0);
    chk("sb12:mem1", mem1[4], 32'h11AB3344);
    chk("sb12:mem2", mem2[4], 32'h11AB3344);
    acc(1'b1, F3_H, 32'h10, 32'h5555BEEF); exp_acc("sh10", 4, 5, 1, 1, 1'b0, 1'b0, '0);
    chk("sh10:mem1", mem1[4], 32'h11ABBEEF);
    chk("sh10:mem2", mem2[4], 32'h11ABBEEF);

    // sw to the top word: single write cycle, no read.
    acc(1'b1, F3_W, 32'h3FC, 32'hDEADBEEF); exp_acc("sw3fc", 2, 2, 0, 1, 1'b0, 1'b0, '0);
    chk("sw3fc:waddr", {22'b0, wa1}, 32'h0FF);
    chk("sw3fc:mem1", mem1[255], 32'hDEADBEEF);
    acc(1'b0, F3_W, 32'h3FC,  '0); exp_acc("lw3fc",  3, 4, 1, 0, 1'b0, 1'b1, 32'hDEADBEEF);
    acc(1'b0, F3_W, 32'h13FC, '0); exp_acc("lwwrap", 3, 4, 1, 0, 1'b0, 1'b1, 32'hDEADBEEF);

    // Rejected accesses: oDone+oErr at k+2, result zero, no RAM enables.
    acc(1'b0, F3_W,   32'h6,  '0);    exp_acc("rej_lw6",  2, 2, 0, 0, 1'b1, 1'b1, 32'h0);
    acc(1'b0, F3_H,   32'h5,  '0);    exp_acc("rej_lh5",  2, 2, 0, 0, 1'b1, 1'b1, 32'h0);
    acc(1'b1, 3'b100, 32'h10, 32'h1); exp_acc("rej_sbu",  2, 2, 0, 0, 1'b1, 1'b1, 32'h0);
    acc(1'b0, 3'b011, 32'h0,  '0);    exp_acc("rej_f011", 2, 2, 0, 0, 1'b1, 1'b1, 32'h0);
    chk("rej:mem1", mem1[4], 32'h11ABBEEF);

    // Reset in u1's WR cycle of an sb (u2 is still in WAIT then).
    acc(1'b0, F3_W, 32'h4, '0);  // leave a nonzero result to be cleared
    @(negedge clk);
    wr = 1'b1; f3 = F3_B; addr = 32'h13; wdata = 32'h77; req1 = 1'b1; req2 = 1'b1;
    @(posedge clk);
    @(negedge clk); req1 = 1'b0; req2 = 1'b0;  // k+1 RD
    @(negedge clk);                            // k+2 WAIT
    @(negedge clk);                            // k+3 WR (u1)
    chk("rst:wr_state1", {31'b0, wren1}, 32'd1);
    rst = 1'b1;
    #1 chk("rst:wr_gated1", {31'b0, wren1}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rstmid");
    rst = 1'b0;
    chk("rstmid:mem1", mem1[4], 32'h11ABBEEF);
    chk("rstmid:mem2", mem2[4], 32'h11ABBEEF);

    // Requests while busy are ignored: lw accepted, then an sw presented during it.
    @(negedge clk);
    wr = 1'b0; f3 = F3_W; addr = 32'h4; wdata = '0; req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);  // k+1
    wr = 1'b1; addr = 32'h10; wdata = 32'h00000BAD;
    wseen = int'(wren1);
    @(negedge clk);  // k+2
    wseen += int'(wren1);
    @(negedge clk);  // k+3
    chk("busyreq:done", {31'b0, done1}, 32'd1);
    chk("busyreq:res", rdat1, 32'h80FF7F01);
    req1 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      wseen += int'(wren1) + int'(busy1);
    end
    chk("busyreq:nowrite", wseen, 0);
    chk("busyreq:mem", mem1[4], 32'h11ABBEEF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access unit between the RV32I core datapath and the word-wide data RAM. It executes lb/lh/lw/lbu/lhu/sb/sh/sw:
- extracts and sign- or zero-extends loaded sub-words;
- performs read-modify-write for sub-word stores, because the RAM has no byte enables;
- flags misaligned or illegal accesses without touching memory.

The core holds its request stable until `oDone`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: RAM word-address width; `oMemAddr = addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses wrap.
- `MEM_LAT`, default 1: cycles from `oMemRden` high to `iMemQ` valid. Legal values 1..2.

Ports:
- `iCLK` in 1: single clock for the unit and the RAM.
- `iRST` in 1: reset, synchronous, active-high.
- `iReq` in 1: access request. Sampled only in IDLE.
- `iWrite` in 1: 1 = store, 0 = load.
- `iFunct3` in 3: access type. 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `iAddr` in 32: byte address (ALU result).
- `iWData` in 32: store data (rs2). Only the low byte or half is used for sb/sh.
- `oBusy` in/out: out 1. High in every state except IDLE.
- `oDone` out 1: one-cycle completion pulse.
- `oErr` out 1: high with `oDone` when the access was rejected.
- `oRData` out 32: extended load result. Valid while `oDone` is high and held until the next accept.
- `oMemAddr` out `ADDR_WIDTH`: RAM word address.
- `oMemWData` out 32: RAM write data.
- `oMemWren` out 1: RAM write enable.
- `oMemRden` out 1: RAM read enable.
- `iMemQ` in 32: RAM read data.

## Operation
- States: IDLE, RD, WAIT, WR, DONE, ERR.
- IDLE with `iReq=1`:
  - Register `iAddr`, `iWData`, `iFunct3` and `iWrite`.
  - Check legality, then go to the first state of the access:

| Condition | Next state |
|---|---|
| Illegal access (see below) | ERR |
| Load | RD |
| sw | WR |
| sb or sh | RD |

- Illegal accesses:
  - h/hu with `addr[0]=1`.
  - w with `addr[1:0]≠0`.
  - funct3 011, 110 or 111.
  - Store with funct3 100 or 101.
- RD: `oMemRden=1`, `oMemAddr` driven from the registered address. Next state WAIT.
- WAIT:
  - Lasts `MEM_LAT` cycles (down-counter).
  - On the last cycle, capture `iMemQ`.
  - Load: extract the byte or half selected by `addr[1:0]`, extend it per funct3 into the result register, then go to DONE.
  - Sub-word store: merge the new byte or half into the captured word at lane `addr[1:0]`, then go to WR.
- WR: `oMemWren = ~iRST`. `oMemWData` is the merged word, or `iWData` for sw. Next state DONE.
- DONE: `oDone=1`, `oErr=0`. Next state IDLE.
- ERR: `oDone=1`, `oErr=1`, `oRData=0`. Next state IDLE. No RAM enable is ever asserted on this path.
- `iReq` is ignored in every state except IDLE. There is no queueing.
- `iRST` high in any state returns the unit to IDLE at the next edge. The write is suppressed by gating, so no partial RMW ever reaches RAM.
- Reset values:
  - `oBusy=0`, `oDone=0`, `oErr=0`.
  - `oRData=0`, `oMemAddr=0`, `oMemWData=0`.
  - `oMemWren=0`, `oMemRden=0`.

## Timing
- Cycle k is the edge at which the request is accepted in IDLE. `oBusy` rises in cycle k+1.
- `oDone` is high in these cycles:

| Access | `oDone` cycle | With `MEM_LAT=1` |
|---|---|---|
| Load | k+2+MEM_LAT | k+3 |
| sw | k+2 | k+2 |
| sb/sh | k+3+MEM_LAT | k+4 |
| Rejected | k+2 | k+2 |

- After DONE or ERR the unit returns to IDLE. The earliest next accept is at the edge that ends the DONE/ERR cycle plus one, i.e. one IDLE cycle between accesses.
- RAM enables are registered-state decodes: at most one of `oMemRden` and `oMemWren` is high in any cycle.
- A RAM write commits at the end of the WR cycle. A load from the same word that follows back-to-back returns the new data.

## Structure
- Shared package `lsu_pkg`:
  - State enum.
  - Funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - The legality function.
- One combinational sub-module, `lsu_align`:
  - (word, `addr[1:0]`, funct3) → extended load value.
  - (word, new data, `addr[1:0]`, funct3) → merged store word.
- The FSM, registers and counter stay in `load_store_unit`.

## Test plan
- RAM word 0x4 = 0x80FF7F01:
  - lb 0x7 → `oRData` 0xFFFFFF80.
  - lbu 0x7 → 0x00000080.
  - lh 0x6 → 0xFFFF80FF.
  - lw 0x4 → 0x80FF7F01.
  - Each `oDone` arrives at k+3.
- RAM word 0x10 = 0x11223344:
  - sb 0xAB to 0x12 → RAM 0x11AB3344, `oDone` at k+4.
  - Then sh 0xBEEF to 0x10 → RAM 0x11ABBEEF.
- sw 0xDEADBEEF to 0x3FC → `oMemWren` exactly one cycle with `oMemAddr=0xFF`, `oDone` at k+2. A subsequent lw 0x3FC returns 0xDEADBEEF.
- Rejected accesses, each giving `oDone`=`oErr`=1 at k+2, `oRData=0`, no RAM enable seen:
  - lw 0x6.
  - lh 0x5.
  - sb with funct3 100.
  - funct3 011.
- Reset during an sb:
  - `iRST` pulsed in the WR cycle → RAM unchanged, unit in IDLE, all outputs at their reset values.
  - `iReq` pulsed while busy → ignored.
- `MEM_LAT=2` build: load `oDone` at k+4, sb `oDone` at k+5, results as in the first scenario.
